read_stage_rr_arbiter_n: RTL and testbench
==========================================

Name: read_stage_rr_arbiter_n

Overview:
- N-channel round-robin arbiter for the lane read stage, generalising the single-channel read-stage arbiter.
- Selects one read request per cycle among N requesters: VRF read ports, mask/accumulate sources and cross-lane readers.
- Holds the winner in a one-entry output register. This gives fair bandwidth sharing and breaks the ready/valid timing path into the VRF bank.
- Sits between read-request producers and a single VRF read bank port.

Parameters:
- N, 4, number of requesting channels (1..16).
- VS_W, 5, vector register index width.
- OFF_W, 4, offset width.
- GRP_W, 4, groupIndex width (consumed, not forwarded).
- SRC_W, 4, readSource width.
- IDX_W, 3, instructionIndex width.
- CHOSEN_W, max(1,$clog2(N)), width of the chosen-index output.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  N  per-channel request valid.
- io_in_ready  out  N  per-channel accept.
- io_in_bits_vs  in  N*VS_W  packed, channel i at [i*VS_W +: VS_W].
- io_in_bits_offset  in  N*OFF_W  packed.
- io_in_bits_groupIndex  in  N*GRP_W  packed; ignored except for lint sink.
- io_in_bits_readSource  in  N*SRC_W  packed.
- io_in_bits_instructionIndex  in  N*IDX_W  packed.
- io_out_ready  in  1  downstream accept.
- io_out_valid  out  1  registered request valid.
- io_out_bits_vs  out  VS_W.
- io_out_bits_offset  out  OFF_W.
- io_out_bits_readSource  out  SRC_W.
- io_out_bits_instructionIndex  out  IDX_W.
- io_out_chosen  out  CHOSEN_W  index of the channel that produced the current output.

Behaviour:
- State: `last_grant` pointer (CHOSEN_W bits), `out_valid`, and the output payload register (including chosen).
- Reset values:
  - `last_grant` = N-1, so channel 0 has first priority.
  - `out_valid` = 0; all output bits and io_out_chosen = 0.
  - io_in_ready = 0 while reset is high.
- `slot_free` = !out_valid | io_out_ready. Pipe-style: the slot is refilled in the same cycle it drains.
- Grant (combinational):
  - Scan channels (last_grant+1) mod N upward, wrapping.
  - The first valid channel is granted. If no channel is valid, there is no grant.
- io_in_ready[i] = slot_free & (i == grant index) & some valid. At most one bit of io_in_ready is high.
- io_in_ready must not depend on io_in_valid[i] of channel i itself except through grant selection. No combinational path from io_out_ready to io_out_valid.
- Accept (io_in_valid[g] & io_in_ready[g]):
  - Payload and chosen = g are loaded.
  - out_valid = 1 next cycle.
  - last_grant = g.
- Latency: exactly 1 cycle from input handshake to io_out_valid.
- Drain without refill (io_out_ready=1, no accept): out_valid -> 0.
- Stall (out_valid=1, io_out_ready=0):
  - All io_in_ready = 0.
  - Output payload is held stable.
  - last_grant is unchanged.
- Pointer moves only on accept. A channel that drops valid before being granted loses nothing.
- Fairness: with all N channels continuously valid and no stalls, each channel is granted exactly once in every N consecutive grants.
- N=1: degenerates to a 1-deep registered pass-through; pointer logic is constant.
- Reset mid-operation: a pending output is discarded (out_valid=0 next cycle) and the pointer returns to N-1.

Decomposition:
- Shared package `read_stage_pkg`:
  - Width constants VS_W/OFF_W/GRP_W/SRC_W/IDX_W.
  - Packed struct `read_req_t` {vs, offset, groupIndex, readSource, instructionIndex}.
  - Output struct `read_out_t` without groupIndex.
- One natural sub-module: `rr_grant_n`. It is purely combinational: rotate-priority picker taking valid[N] and last_grant, returning a one-hot grant plus its index. It is reusable by other lane arbiters.
- The top level holds the pointer, the output register and the handshake.

Test Plan:
- Reset release, no valids (N=4) -> io_out_valid=0, io_in_ready=0000, io_out_chosen=0 for 5 cycles.
- All four valid, io_out_ready=1 for 8 cycles -> chosen sequence 0,1,2,3,0,1,2,3 appears one cycle after each accept; one accept per cycle.
- Only ch2 valid with vs=5'h1A, offset=4'h3, readSource=4'h9, instructionIndex=3'h5 -> next cycle out = {1A,3,9,5}, chosen=2; groupIndex value does not appear.
- Output stall: out_valid=1, io_out_ready=0 for 3 cycles with ch0/ch1 valid -> io_in_ready=0000, payload constant. On release, ready the same cycle, the next grant follows last_grant+1.
- Sparse valids ch1,ch3 after last grant=1 -> ch3 granted, then ch1; channels 0/2 are skipped with no bubble.
- Assert reset while out_valid=1 -> the next cycle has out_valid=0 and last_grant=3; with all valid afterward, the first chosen=0.

Source files
------------

// File: rtl/read_stage_pkg.sv
// Shared types for the lane read stage arbiters.
// Request payload layout and width constants.
package read_stage_pkg;

  localparam int VS_W  = 5;
  localparam int OFF_W = 4;
  localparam int GRP_W = 4;
  localparam int SRC_W = 4;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [VS_W-1:0]  vs;
    logic [OFF_W-1:0] offset;
    logic [GRP_W-1:0] group_index;
    logic [SRC_W-1:0] read_source;
    logic [IDX_W-1:0] instruction_index;
  } read_req_t;

  typedef struct packed {
    logic [VS_W-1:0]  vs;
    logic [OFF_W-1:0] offset;
    logic [SRC_W-1:0] read_source;
    logic [IDX_W-1:0] instruction_index;
  } read_out_t;

  function automatic int chosen_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic read_out_t strip_group(
    read_req_t r
  );
    read_out_t o;
    o.vs                = r.vs;
    o.offset            = r.offset;
    o.read_source       = r.read_source;
    o.instruction_index = r.instruction_index;
    return o;
  endfunction

endpackage

// File: rtl/read_stage_rr_arbiter_n_if.sv
// Request-side and bank-side bundle of the N-channel read arbiter.
// master drives requests and io_out_ready; slave is the arbiter.
interface read_stage_rr_arbiter_n_if
  import read_stage_pkg::*;
#(
  parameter int N = 4
);

  localparam int CHOSEN_W = chosen_w(N);

  logic [N-1:0]         io_in_valid;
  logic [N-1:0]         io_in_ready;
  logic [N*VS_W-1:0]    io_in_bits_vs;
  logic [N*OFF_W-1:0]   io_in_bits_offset;
  logic [N*GRP_W-1:0]   io_in_bits_groupIndex;
  logic [N*SRC_W-1:0]   io_in_bits_readSource;
  logic [N*IDX_W-1:0]   io_in_bits_instructionIndex;

  logic                 io_out_ready;
  logic                 io_out_valid;
  logic [VS_W-1:0]      io_out_bits_vs;
  logic [OFF_W-1:0]     io_out_bits_offset;
  logic [SRC_W-1:0]     io_out_bits_readSource;
  logic [IDX_W-1:0]     io_out_bits_instructionIndex;
  logic [CHOSEN_W-1:0]  io_out_chosen;

  modport master (
    output io_in_valid,
    output io_in_bits_vs,
    output io_in_bits_offset,
    output io_in_bits_groupIndex,
    output io_in_bits_readSource,
    output io_in_bits_instructionIndex,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_bits_vs,
    input  io_out_bits_offset,
    input  io_out_bits_readSource,
    input  io_out_bits_instructionIndex,
    input  io_out_chosen
  );

  modport slave (
    input  io_in_valid,
    input  io_in_bits_vs,
    input  io_in_bits_offset,
    input  io_in_bits_groupIndex,
    input  io_in_bits_readSource,
    input  io_in_bits_instructionIndex,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_bits_vs,
    output io_out_bits_offset,
    output io_out_bits_readSource,
    output io_out_bits_instructionIndex,
    output io_out_chosen
  );

endinterface

// File: rtl/rr_grant_n.sv
// Rotating-priority picker: first valid channel after last_grant.
// Purely combinational, shared by the lane arbiters.
module rr_grant_n #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] last_grant,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_valid
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (int'(last_grant) + k) % N;
      if (!any_valid && valid[c]) begin
        any_valid = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = W'(c);
      end
    end
  end

endmodule

// File: rtl/read_stage_rr_arbiter_n.sv
// N-channel round-robin read-request arbiter feeding one VRF bank port.
// Winner lands in a one-entry register that refills as it drains.
module read_stage_rr_arbiter_n
  import read_stage_pkg::*;
#(
  parameter int N = 4
) (
  input logic clock,
  input logic reset,
  read_stage_rr_arbiter_n_if.slave io
);

  localparam int CHOSEN_W = chosen_w(N);

  read_req_t           reqs [N];
  read_out_t           sel;
  read_out_t           out_q;
  logic [CHOSEN_W-1:0] last_grant;
  logic [CHOSEN_W-1:0] grant_idx;
  logic [CHOSEN_W-1:0] chosen_q;
  logic [N-1:0]        grant;
  logic                any_valid;
  logic                out_valid_q;
  logic                slot_free;
  logic                accept;
  logic                unused_grp;

  always_comb begin
    unused_grp = 1'b0;
    for (int i = 0; i < N; i++) begin
      reqs[i] = '{
        vs:                io.io_in_bits_vs[i*VS_W +: VS_W],
        offset:            io.io_in_bits_offset[i*OFF_W +: OFF_W],
        group_index:       io.io_in_bits_groupIndex[i*GRP_W +: GRP_W],
        read_source:       io.io_in_bits_readSource[i*SRC_W +: SRC_W],
        instruction_index: io.io_in_bits_instructionIndex[i*IDX_W +: IDX_W]
      };
      unused_grp = unused_grp ^ (^reqs[i].group_index);
    end
  end

  rr_grant_n #(
    .N (N),
    .W (CHOSEN_W)
  ) u_grant (
    .valid      (io.io_in_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  assign slot_free = !out_valid_q || io.io_out_ready;

  always_comb begin
    io.io_in_ready = '0;
    if (!reset && slot_free && any_valid) begin
      io.io_in_ready = grant;
    end
  end

  assign accept = |(io.io_in_valid & io.io_in_ready);

  // grant is one-hot, so an OR-mux avoids indexing past N
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel = sel | strip_group(reqs[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant  <= CHOSEN_W'(N - 1);
      out_valid_q <= 1'b0;
      out_q       <= '0;
      chosen_q    <= '0;
    end else if (accept) begin
      last_grant  <= grant_idx;
      out_valid_q <= 1'b1;
      out_q       <= sel;
      chosen_q    <= grant_idx;
    end else if (io.io_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.io_out_valid                 = out_valid_q;
  assign io.io_out_bits_vs               = out_q.vs;
  assign io.io_out_bits_offset           = out_q.offset;
  assign io.io_out_bits_readSource       = out_q.read_source;
  assign io.io_out_bits_instructionIndex = out_q.instruction_index;
  assign io.io_out_chosen                = chosen_q;

endmodule

// File: tb/tb_read_stage_rr_arbiter_n.sv
// Bench for read_stage_rr_arbiter_n (N=4): scenario tasks plus
// a posedge model that predicts grants and scoreboards payloads.
module tb_read_stage_rr_arbiter_n;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  read_stage_rr_arbiter_n_if #(.N(N)) io ();

  read_stage_rr_arbiter_n #(.N(N)) dut (
    .clock (clk),
    .reset (rst),
    .io    (io)
  );

  logic [17:0] sbq [$];
  int          m_ptr;
  logic        m_ov;

  always @(posedge clk) begin
    int          g;
    logic [3:0]  exp_rdy;
    logic [17:0] exp_item;
    logic [17:0] got;
    if (rst) begin
      m_ptr = N - 1;
      m_ov  = 1'b0;
      sbq.delete();
    end else begin
      checks++;
      if (io.io_out_valid !== m_ov) begin
        errors++;
        $display("FAIL mon_out_valid got=%b exp=%b", io.io_out_valid, m_ov);
      end
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && io.io_in_valid[c]) g = c;
      end
      exp_rdy = 4'b0000;
      if (g >= 0 && (!m_ov || io.io_out_ready)) exp_rdy[g] = 1'b1;
      checks++;
      if (io.io_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL mon_in_ready got=%b exp=%b", io.io_in_ready, exp_rdy);
      end
      if (m_ov && io.io_out_ready) begin
        got = {io.io_out_bits_vs, io.io_out_bits_offset,
               io.io_out_bits_readSource,
               io.io_out_bits_instructionIndex, io.io_out_chosen};
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=%h exp=none", got);
        end else begin
          exp_item = sbq.pop_front();
          if (got !== exp_item) begin
            errors++;
            $display("FAIL sb_payload got=%h exp=%h", got, exp_item);
          end
        end
      end
      if (exp_rdy != 4'b0000) begin
        sbq.push_back({io.io_in_bits_vs[g*5 +: 5],
                       io.io_in_bits_offset[g*4 +: 4],
                       io.io_in_bits_readSource[g*4 +: 4],
                       io.io_in_bits_instructionIndex[g*3 +: 3],
                       2'(g)});
        m_ptr = g;
        m_ov  = 1'b1;
      end else if (io.io_out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic set_ch(input int i, input logic [4:0] vs,
                        input logic [3:0] off, input logic [3:0] grp,
                        input logic [3:0] src, input logic [2:0] idx);
    io.io_in_bits_vs[i*5 +: 5]               = vs;
    io.io_in_bits_offset[i*4 +: 4]           = off;
    io.io_in_bits_groupIndex[i*4 +: 4]       = grp;
    io.io_in_bits_readSource[i*4 +: 4]       = src;
    io.io_in_bits_instructionIndex[i*3 +: 3] = idx;
  endtask

  task automatic test_reset;
    io.io_in_valid = 4'hF;
    #1;
    checks++;
    if (io.io_in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready_in_reset got=%b exp=0000", io.io_in_ready);
    end
    io.io_in_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (io.io_out_valid !== 1'b0 || io.io_in_ready !== 4'b0000 ||
          io.io_out_chosen !== 2'd0) begin
        errors++;
        $display("FAIL rst_idle got=%b/%b/%0d exp=0/0000/0",
                 io.io_out_valid, io.io_in_ready, io.io_out_chosen);
      end
    end
    checks++;
    if (dut.last_grant !== 2'd3) begin
      errors++;
      $display("FAIL rst_ptr got=%0d exp=3", dut.last_grant);
    end
  endtask

  task automatic test_rotation;
    for (int i = 0; i < N; i++)
      set_ch(i, 5'(8 + i), 4'(i), 4'hF, 4'(15 - i), 3'(i));
    io.io_out_ready = 1'b1;
    io.io_in_valid  = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (io.io_out_valid !== 1'b1 || io.io_out_chosen !== 2'(k % 4)) begin
        errors++;
        $display("FAIL rot_chosen[%0d] got=%b/%0d exp=1/%0d",
                 k, io.io_out_valid, io.io_out_chosen, k % 4);
      end
      checks++;
      if ($countones(io.io_in_ready) != 1) begin
        errors++;
        $display("FAIL rot_onehot got=%b exp=one_bit", io.io_in_ready);
      end
    end
    io.io_in_valid = 4'h0;
    @(negedge clk);
    checks++;
    if (io.io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rot_drain got=%b exp=0", io.io_out_valid);
    end
  endtask

  task automatic test_payload;
    set_ch(2, 5'h1A, 4'h3, 4'hC, 4'h9, 3'h5);
    io.io_in_valid = 4'b0100;
    @(negedge clk);
    io.io_in_valid = 4'h0;
    checks++;
    if (io.io_out_bits_vs !== 5'h1A || io.io_out_bits_offset !== 4'h3 ||
        io.io_out_bits_readSource !== 4'h9 ||
        io.io_out_bits_instructionIndex !== 3'h5 ||
        io.io_out_chosen !== 2'd2) begin
      errors++;
      $display("FAIL payload got=%h/%h/%h/%h/%0d exp=1a/3/9/5/2",
               io.io_out_bits_vs, io.io_out_bits_offset,
               io.io_out_bits_readSource,
               io.io_out_bits_instructionIndex, io.io_out_chosen);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic [15:0] held;
    set_ch(0, 5'h05, 4'hA, 4'h1, 4'h2, 3'h6);
    set_ch(1, 5'h11, 4'h7, 4'h2, 4'hE, 3'h1);
    io.io_out_ready = 1'b0;
    io.io_in_valid  = 4'b0011;
    @(negedge clk);
    checks++;
    if (io.io_out_valid !== 1'b1 || io.io_out_chosen !== 2'd0) begin
      errors++;
      $display("FAIL stall_first got=%b/%0d exp=1/0",
               io.io_out_valid, io.io_out_chosen);
    end
    held = {5'h05, 4'hA, 4'h2, 3'h6};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (io.io_in_ready !== 4'b0000 || io.io_out_chosen !== 2'd0 ||
          {io.io_out_bits_vs, io.io_out_bits_offset,
           io.io_out_bits_readSource,
           io.io_out_bits_instructionIndex} !== held) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%b/%h exp=0000/%h", k,
                 io.io_in_ready,
                 {io.io_out_bits_vs, io.io_out_bits_offset,
                  io.io_out_bits_readSource,
                  io.io_out_bits_instructionIndex}, held);
      end
    end
    io.io_out_ready = 1'b1;
    #1;
    checks++;
    if (io.io_in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release got=%b exp=0010", io.io_in_ready);
    end
    @(negedge clk);
    io.io_in_valid = 4'h0;
    checks++;
    if (io.io_out_chosen !== 2'd1) begin
      errors++;
      $display("FAIL stall_next got=%0d exp=1", io.io_out_chosen);
    end
    @(negedge clk);
  endtask

  task automatic test_sparse;
    io.io_in_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (io.io_out_valid !== 1'b1 || io.io_out_chosen !== 2'd3) begin
      errors++;
      $display("FAIL sparse_a got=%b/%0d exp=1/3",
               io.io_out_valid, io.io_out_chosen);
    end
    @(negedge clk);
    io.io_in_valid = 4'h0;
    checks++;
    if (io.io_out_valid !== 1'b1 || io.io_out_chosen !== 2'd1) begin
      errors++;
      $display("FAIL sparse_b got=%b/%0d exp=1/1",
               io.io_out_valid, io.io_out_chosen);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    io.io_out_ready = 1'b0;
    io.io_in_valid  = 4'hF;
    @(negedge clk);
    checks++;
    if (io.io_out_valid !== 1'b1 || io.io_out_chosen !== 2'd2) begin
      errors++;
      $display("FAIL rmid_pending got=%b/%0d exp=1/2",
               io.io_out_valid, io.io_out_chosen);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (io.io_out_valid !== 1'b0 || dut.last_grant !== 2'd3 ||
        io.io_in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_cleared got=%b/%0d/%b exp=0/3/0000",
               io.io_out_valid, dut.last_grant, io.io_in_ready);
    end
    rst = 1'b0;
    io.io_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (io.io_out_valid !== 1'b1 || io.io_out_chosen !== 2'd0) begin
      errors++;
      $display("FAIL rmid_first got=%b/%0d exp=1/0",
               io.io_out_valid, io.io_out_chosen);
    end
    io.io_in_valid = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    io.io_in_valid                 = '0;
    io.io_in_bits_vs               = '0;
    io.io_in_bits_offset           = '0;
    io.io_in_bits_groupIndex       = '0;
    io.io_in_bits_readSource       = '0;
    io.io_in_bits_instructionIndex = '0;
    io.io_out_ready                = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_rotation;
    test_payload;
    test_stall;
    test_sparse;
    test_reset_mid;
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
